// File: rtl/msg_printer_pkg.sv
// Shared types and message ROM for the event message printer.
package msg_printer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT} state_e;
  typedef enum logic {MSG_ALARM, MSG_SW} msg_sel_e;

  localparam int IDX_W = 3;

  // Index 0 is the first byte on the wire.
  localparam logic [0:7][7:0] ALARM_MSG = {8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h21, 8'h0D, 8'h0A};
  localparam logic [0:3][7:0] SW_MSG    = {8'h53, 8'h57, 8'h0D, 8'h0A};

  localparam logic [IDX_W-1:0] ALARM_LAST = 3'd7;
  localparam logic [IDX_W-1:0] SW_LAST    = 3'd3;

  function automatic logic [7:0] msg_byte(input msg_sel_e sel, input logic [IDX_W-1:0] idx);
    case (sel)
      MSG_ALARM: msg_byte = ALARM_MSG[idx];
      default:   msg_byte = SW_MSG[idx[1:0]];
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] msg_last(input msg_sel_e sel);
    msg_last = (sel == MSG_ALARM) ? ALARM_LAST : SW_LAST;
  endfunction

endpackage

// File: rtl/msg_printer_uart_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [7:0]       sh_q;
  logic             tx_q, done_q, act_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      // Registered one cycle early so done is high during the last stop-bit cycle.
      done_q <= act_q && (bit_q == 4'd9) && (cnt_q == CNT_DONE);
      if (!act_q) begin
        if (start) begin
          act_q <= 1'b1;
          tx_q  <= 1'b0;
          sh_q  <= data;
          bit_q <= '0;
          cnt_q <= '0;
        end
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          act_q <= 1'b0;
          bit_q <= '0;
        end else begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_q <= 1'b1;
          end else begin
            tx_q <= sh_q[0];
            sh_q <= {1'b0, sh_q[7:1]};
          end
        end
      end
    end
  end

  assign tx      = tx_q;
  assign done    = done_q;
  assign tx_busy = act_q;

endmodule

// File: rtl/msg_printer.sv
// Queues fixed ASCII messages for switch/alarm pulses and prints them over UART.
module msg_printer
  import msg_printer_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_sw,
  input  logic trig_alarm,
  output logic tx,
  output logic busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  state_e           state_q;
  msg_sel_e         sel_q;
  logic [IDX_W-1:0] idx_q;
  logic             pend_alarm_q, pend_alarm_d;
  logic             pend_sw_q, pend_sw_d;
  logic             start_q, busy_q;
  logic             ser_done, ser_busy;
  logic             clr_alarm, clr_sw;

  // Alarm wins when both are pending; a same-cycle trigger re-arms a cleared flag.
  assign clr_alarm    = (state_q == ST_IDLE) && pend_alarm_q;
  assign clr_sw       = (state_q == ST_IDLE) && !pend_alarm_q && pend_sw_q;
  assign pend_alarm_d = (pend_alarm_q && !clr_alarm) || trig_alarm;
  assign pend_sw_d    = (pend_sw_q && !clr_sw) || trig_sw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_alarm_q <= 1'b0;
      pend_sw_q    <= 1'b0;
    end else begin
      pend_alarm_q <= pend_alarm_d;
      pend_sw_q    <= pend_sw_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= MSG_ALARM;
      idx_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_alarm_q || pend_sw_q) begin
            sel_q   <= pend_alarm_q ? MSG_ALARM : MSG_SW;
            state_q <= ST_LOAD;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          start_q <= 1'b0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (ser_done) begin
            if (idx_q == msg_last(sel_q)) begin
              state_q <= ST_WAIT;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_LOAD;
              start_q <= 1'b1;
            end
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start  (start_q && !ser_busy),
    .data   (msg_byte(sel_q, idx_q)),
    .tx     (tx),
    .done   (ser_done),
    .tx_busy(ser_busy)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_msg_printer.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART monitor decodes tx and compares.
module tb_msg_printer;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig_sw = 1'b0;
  logic trig_alarm = 1'b0;
  logic tx, busy;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  msg_printer #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig_sw   (trig_sw),
    .trig_alarm(trig_alarm),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic a, input logic s);
    trig_alarm = a;
    trig_sw    = s;
    @(negedge clk);
    trig_alarm = 1'b0;
    trig_sw    = 1'b0;
  endtask

  task automatic push_alarm();
    logic [7:0] m [8] = '{8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h21, 8'h0D, 8'h0A};
    foreach (m[i]) exp_q.push_back(m[i]);
  endtask

  task automatic push_sw();
    logic [7:0] m [4] = '{8'h53, 8'h57, 8'h0D, 8'h0A};
    foreach (m[i]) exp_q.push_back(m[i]);
  endtask

  task automatic wait_quiet(input string name, input int b0, input int exp_busy);
    int n = 0;
    int quiet = 0;
    while (n < 4000 && !(quiet >= 3 && exp_q.size() == 0)) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) quiet = 0; else quiet++;
    end
    check({name, "_timeout"}, n < 4000, 1);
    check({name, "_busy_cycles"}, busy_cnt - b0, exp_busy);
  endtask

  // UART decoder: samples mid-bit, discards frames interrupted by reset.
  initial begin
    logic [7:0] got;
    logic sb, pb, ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        sb = 1'b1;
        pb = 1'b0;
        got = '0;
        for (int c = 1; c <= CPB / 2 + 9 * CPB; c++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1'b1;
          if (c == CPB / 2) sb = tx;
          else if (c > CPB / 2 && (c - CPB / 2) % CPB == 0) begin
            if ((c - CPB / 2) / CPB <= 8) got[(c - CPB / 2) / CPB - 1] = tx;
            else pb = tx;
          end
        end
        if (!ab) begin
          check("start_bit", sb, 0);
          check("stop_bit", pb, 1);
          if (exp_q.size() == 0) check("unexpected_byte", got, 32'hFFFF_FFFF);
          else check("byte", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int b0, errs, act;
    logic [9:0] fr;

    // Reset with triggers active
    rst = 1'b0;
    trig_sw = 1'b1;
    trig_alarm = 1'b1;
    cyc(5);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    trig_sw = 1'b0;
    trig_alarm = 1'b0;
    cyc(1);
    rst = 1'b1;
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    check("post_rst_silent", act, 0);

    // Single SW message with exact start latency
    b0 = busy_cnt;
    push_sw();
    pulse(1'b0, 1'b1);
    check("sw_busy_k", busy, 0);
    @(negedge clk);
    check("sw_busy_k1", busy, 1);
    check("sw_tx_k1", tx, 1);
    @(negedge clk);
    check("sw_tx_k2", tx, 0);
    wait_quiet("sw", b0, 405);

    // Bit timing of the first ALARM byte (0x41), then inter-byte gap
    b0 = busy_cnt;
    push_alarm();
    pulse(1'b1, 1'b0);
    cyc(2);
    fr = {1'b1, 8'h41, 1'b0};
    errs = 0;
    for (int c = 0; c < 102; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 100) begin
        if (tx !== fr[c / 10]) errs++;
      end else if (c == 100) begin
        if (tx !== 1'b1) errs++;
      end else if (tx !== 1'b0) errs++;
    end
    check("bit_timing", errs, 0);
    wait_quiet("alarm", b0, 809);

    // Simultaneous triggers: alarm first, then switch
    b0 = busy_cnt;
    push_alarm();
    push_sw();
    pulse(1'b1, 1'b1);
    wait_quiet("both", b0, 1214);

    // Three switch re-triggers during an alarm collapse to one message
    b0 = busy_cnt;
    push_alarm();
    push_sw();
    pulse(1'b1, 1'b0);
    cyc(48);
    pulse(1'b0, 1'b1);
    cyc(250);
    pulse(1'b0, 1'b1);
    cyc(400);
    pulse(1'b0, 1'b1);
    wait_quiet("retrig", b0, 1214);

    // Reset during the third ALARM byte also drops a pending switch request
    push_alarm();
    pulse(1'b1, 1'b0);
    cyc(100);
    pulse(1'b0, 1'b1);
    cyc(129);
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    cyc(3);
    check("midrst_bytes_left", exp_q.size(), 6);
    exp_q.delete();
    rst = 1'b1;
    act = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) act++;
    end
    check("midrst_silent", act, 0);

    // Fresh trigger after reset still prints
    b0 = busy_cnt;
    push_sw();
    pulse(1'b0, 1'b1);
    wait_quiet("after_rst", b0, 405);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
